vid_timing_gen: RTL and testbench
=================================

Name: vid_timing_gen

Overview:
Parametrised raster timing generator for the video controller. It generalises the fixed 5-clock pixel, 15-pixel line and 10-line frame counters to programmable widths, divider, porches and sync polarity. It adds shadowed configuration applied at frame boundaries, a graceful stop and config error checking. Its outputs pace pixel FIFO reads and drive the hsync, hblank, vsync and vblank pins.

Parameters:
CNT_W, 13, width of all horizontal and vertical position and config fields.
DIV_W, 6, width of the pixel clock divider field.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
en  in  1  run enable: level-sensitive start, graceful stop.
cfg_load  in  1  one-cycle pulse to capture all cfg_* inputs.
cfg_pcnt  in  DIV_W  clocks per pixel minus 1.
cfg_hsize  in  CNT_W  displayed pixels per line.
cfg_hend  in  CNT_W  last pixel index of line (total minus 1).
cfg_hs_start  in  CNT_W  first hsync pixel.
cfg_hs_end  in  CNT_W  first pixel after hsync.
cfg_vsize  in  CNT_W  displayed lines per frame.
cfg_vend  in  CNT_W  last line index of frame.
cfg_vs_start  in  CNT_W  first vsync line.
cfg_vs_end  in  CNT_W  first line after vsync.
cfg_hpol  in  1  1 = hsync active-low.
cfg_vpol  in  1  1 = vsync active-low.
pix_ce  out  1  one-cycle pixel strobe.
hcount  out  CNT_W  current pixel index.
vcount  out  CNT_W  current line index.
hsync, vsync  out  1  sync outputs, polarity applied.
hblank, vblank  out  1  blanking flags.
de  out  1  ~hblank & ~vblank; FIFO read qualifier is pix_ce & de.
line_start  out  1  one-cycle pulse when hcount becomes 0.
frame_start  out  1  one-cycle pulse when (hcount, vcount) becomes (0, 0).
running  out  1  high in RUN.
cfg_err  out  1  sticky: last cfg_load was rejected.

Behaviour:
- Reset: all outputs 0 except hblank = vblank = 1. Active and pending config cleared; polarity fields = 0. State = IDLE.
- Config validity check, applied on cfg_load: hsize >= 1, hsize <= hend, hs_start < hs_end <= hend + 1, vsize >= 1, vsize <= vend, vs_start < vs_end <= vend + 1.
  - Invalid: cfg_err <= 1; active and pending config unchanged.
  - Valid: cfg_err <= 0.
- Where a valid cfg_load lands:
  - In IDLE: writes the active config directly.
  - In RUN: writes a pending shadow and sets pend_v.
  - A second load before the frame wraps overwrites the pending shadow.
- States: IDLE, RUN, STOPPING.
- IDLE -> RUN when en = 1 and the active config is valid (a valid config was ever loaded). On entry, the same edge sets:
  - counters = (0, 0) and divider = 0;
  - frame_start = 1 and line_start = 1 for one cycle;
  - running = 1.
- Divider: div increments each RUN/STOPPING cycle. When div == pcnt, pix_ce = 1 and div <= 0. With pcnt = 0, pix_ce is high every cycle.
- Counters advance only on pix_ce:
  - hcount == hend -> hcount <= 0;
  - at that wrap, vcount == vend -> vcount <= 0, else vcount + 1;
  - otherwise hcount + 1.
- Frame wrap is the pix_ce with hcount == hend and vcount == vend. On that edge:
  - if pend_v, the pending config becomes active and pend_v clears;
  - the new config governs decode from (0, 0) onward.
- Decode is registered and updated on the same edge as the counters, so all flags are aligned with hcount/vcount:
  - hblank = hcount >= hsize;
  - vblank = vcount >= vsize;
  - hsync = (hs_start <= hcount < hs_end) ^ hpol;
  - vsync = (vs_start <= vcount < vs_end) ^ vpol.
- Stop: en = 0 in RUN -> STOPPING. Counting continues to the frame wrap, then IDLE.
  - en reasserted in STOPPING -> back to RUN with no discontinuity.
- IDLE outputs: hblank = vblank = 1, de = 0, pix_ce = 0, counters held at 0. Syncs sit at their inactive level: hsync = hpol, vsync = vpol.
- Reset mid-frame returns to the full reset state on the next edge, discarding pending config.
- All compares are unsigned at CNT_W bits; hend + 1 is evaluated at CNT_W + 1 bits.

Test Plan:
- Baseline config: pcnt = 4, hsize = 8, hend = 14, hs 10..12, vsize = 6, vend = 9, vs 7..8, pols = 0; load, en = 1 -> pix_ce every 5 clks; line = 75 clks; frame_start period 750 clks; hsync high for hcount 10-11; hblank for hcount 8-14; de count = 48 per frame.
- Polarity: same timing with hpol = vpol = 1 -> hsync low only at hcount 10-11, vsync low only at line 7; in IDLE hsync = vsync = 1.
- Mid-frame reload: valid load with hend = 19 at vcount = 3 -> line stays 15 pixels until the frame wrap, then 20 pixels (100 clks) from the next frame_start.
- Invalid load: hs_end = 16 with hend = 14 -> cfg_err = 1; timing unchanged; a following valid load clears cfg_err.
- Graceful stop: en = 0 at vcount = 4 -> running stays 1 until hcount = 14, vcount = 9 wrap, then IDLE with hblank = vblank = 1; en toggled low-high within the frame -> no gap.
- Edge cases: pcnt = 0 -> pix_ce continuous; reset asserted mid-line -> next cycle all outputs at reset values and pending config lost.

Source files
------------

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator: pixel divider, h/v counters, registered sync/blank decode,
// shadowed configuration applied at frame wrap, graceful stop and config validation.
module vid_timing_gen #(
  parameter int unsigned CNT_W = 13,
  parameter int unsigned DIV_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_pcnt,
  input  logic [CNT_W-1:0] cfg_hsize,
  input  logic [CNT_W-1:0] cfg_hend,
  input  logic [CNT_W-1:0] cfg_hs_start,
  input  logic [CNT_W-1:0] cfg_hs_end,
  input  logic [CNT_W-1:0] cfg_vsize,
  input  logic [CNT_W-1:0] cfg_vend,
  input  logic [CNT_W-1:0] cfg_vs_start,
  input  logic [CNT_W-1:0] cfg_vs_end,
  input  logic             cfg_hpol,
  input  logic             cfg_vpol,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic             running,
  output logic             cfg_err
);

  typedef struct packed {
    logic [DIV_W-1:0] pcnt;
    logic [CNT_W-1:0] hsize;
    logic [CNT_W-1:0] hend;
    logic [CNT_W-1:0] hs_start;
    logic [CNT_W-1:0] hs_end;
    logic [CNT_W-1:0] vsize;
    logic [CNT_W-1:0] vend;
    logic [CNT_W-1:0] vs_start;
    logic [CNT_W-1:0] vs_end;
    logic             hpol;
    logic             vpol;
  } cfg_t;

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e           state_q, state_d;
  cfg_t             cfg_in, act_q, act_d, pend_q, pend_d;
  logic             act_v_q, act_v_d, pend_v_q, pend_v_d, cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [CNT_W:0]   hend_p1, vend_p1;
  logic             cfg_ok, pix_ce_c, h_wrap, frame_wrap;

  assign cfg_in = {cfg_pcnt, cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end,
                   cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end, cfg_hpol, cfg_vpol};

  // Sync end may equal total length, so compare against end + 1 one bit wider.
  assign hend_p1 = {1'b0, cfg_hend} + 1'b1;
  assign vend_p1 = {1'b0, cfg_vend} + 1'b1;
  assign cfg_ok  = (cfg_hsize != '0) && (cfg_hsize <= cfg_hend) &&
                   (cfg_hs_start < cfg_hs_end) && ({1'b0, cfg_hs_end} <= hend_p1) &&
                   (cfg_vsize != '0) && (cfg_vsize <= cfg_vend) &&
                   (cfg_vs_start < cfg_vs_end) && ({1'b0, cfg_vs_end} <= vend_p1);

  assign pix_ce_c   = (state_q != StIdle) && (div_q == act_q.pcnt);
  assign h_wrap     = (h_q == act_q.hend);
  assign frame_wrap = pix_ce_c && h_wrap && (v_q == act_q.vend);

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    act_v_d   = act_v_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    cfg_err_d = cfg_err_q;
    div_d     = div_q;
    h_d       = h_q;
    v_d       = v_q;
    ls_d      = 1'b0;
    fs_d      = 1'b0;

    if (frame_wrap && pend_v_q) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
    end

    if (cfg_load) begin
      if (cfg_ok) begin
        cfg_err_d = 1'b0;
        if (state_q == StIdle) begin
          act_d   = cfg_in;
          act_v_d = 1'b1;
        end else begin
          pend_d   = cfg_in;
          pend_v_d = 1'b1;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (en && act_v_q) begin
          state_d = StRun;
          div_d   = '0;
          h_d     = '0;
          v_d     = '0;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      StRun, StStopping: begin
        if (pix_ce_c) begin
          div_d = '0;
          if (h_wrap) begin
            h_d  = '0;
            ls_d = 1'b1;
            if (v_q == act_q.vend) begin
              v_d  = '0;
              fs_d = 1'b1;
            end else begin
              v_d = v_q + 1'b1;
            end
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end

        if (state_q == StRun) begin
          if (!en) state_d = StStopping;
        end else if (en) begin
          state_d = StRun;
        end else if (frame_wrap) begin
          state_d = StIdle;
          ls_d    = 1'b0;
          fs_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Decode uses next-cycle counters and config so flags line up with hcount/vcount.
    if (state_d == StIdle) begin
      hb_d = 1'b1;
      vb_d = 1'b1;
      hs_d = act_d.hpol;
      vs_d = act_d.vpol;
    end else begin
      hb_d = (h_d >= act_d.hsize);
      vb_d = (v_d >= act_d.vsize);
      hs_d = ((h_d >= act_d.hs_start) && (h_d < act_d.hs_end)) ^ act_d.hpol;
      vs_d = ((v_d >= act_d.vs_start) && (v_d < act_d.vs_end)) ^ act_d.vpol;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      act_q     <= '0;
      act_v_q   <= 1'b0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      act_v_q   <= act_v_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      cfg_err_q <= cfg_err_d;
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
    end
  end

  assign pix_ce      = pix_ce_c;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign hblank      = hb_q;
  assign vblank      = vb_q;
  assign de          = ~hb_q & ~vb_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign running     = (state_q != StIdle);
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen: expected raster state is derived arithmetically from the
// cycle count since run start, queued before each edge and compared after it.
module tb_vid_timing_gen;

  localparam int CW = 13;
  localparam int DW = 6;

  typedef logic [34:0] vec_t;

  logic          clk = 1'b0;
  logic          reset, en, cfg_load;
  logic [DW-1:0] cfg_pcnt;
  logic [CW-1:0] cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end;
  logic [CW-1:0] cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end;
  logic          cfg_hpol, cfg_vpol;
  logic          pix_ce, hsync, vsync, hblank, vblank, de, line_start, frame_start, running;
  logic          cfg_err;
  logic [CW-1:0] hcount, vcount;

  vec_t obs;
  vec_t exp_q[$];
  vec_t exp_v;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   kk;

  // Idle compare ignores the start pulses.
  localparam vec_t IdleMask = {1'b1, 2'b00, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  vid_timing_gen #(.CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load), .cfg_pcnt(cfg_pcnt),
    .cfg_hsize(cfg_hsize), .cfg_hend(cfg_hend), .cfg_hs_start(cfg_hs_start),
    .cfg_hs_end(cfg_hs_end), .cfg_vsize(cfg_vsize), .cfg_vend(cfg_vend),
    .cfg_vs_start(cfg_vs_start), .cfg_vs_end(cfg_vs_end), .cfg_hpol(cfg_hpol),
    .cfg_vpol(cfg_vpol), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount), .hsync(hsync),
    .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
    .frame_start(frame_start), .running(running), .cfg_err(cfg_err)
  );

  assign obs = {running, frame_start, line_start, de, vblank, hblank, vsync, hsync, pix_ce,
                vcount, hcount};

  // k = clocks since the run-start edge; hsize 8, hs 10..12, vsize 6, vend 9, vs 7..8.
  function automatic vec_t exp_at(int k, int pc, int he, bit hp, bit vp);
    int p, h, v, lp;
    logic hb, vb, hs, vs, ls, fs, pce, de_e;
    logic [12:0] hh, vv;
    p    = k / (pc + 1);
    h    = p % (he + 1);
    v    = (p / (he + 1)) % 10;
    lp   = (he + 1) * (pc + 1);
    hb   = (h >= 8);
    vb   = (v >= 6);
    hs   = ((h >= 10) && (h < 12)) ^ hp;
    vs   = (v == 7) ^ vp;
    de_e = !hb && !vb;
    ls   = (k % lp == 0);
    fs   = (k % (lp * 10) == 0);
    pce  = (k % (pc + 1) == pc);
    hh   = h[12:0];
    vv   = v[12:0];
    return {1'b1, fs, ls, de_e, vb, hb, vs, hs, pce, vv, hh};
  endfunction

  function automatic vec_t idle_vec(bit hp, bit vp);
    return {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, vp, hp, 1'b0, 13'd0, 13'd0};
  endfunction

  task automatic set_cfg(int pc, int he, int hse, bit hp, bit vp);
    cfg_pcnt     = DW'(pc);
    cfg_hsize    = 13'd8;
    cfg_hend     = CW'(he);
    cfg_hs_start = 13'd10;
    cfg_hs_end   = CW'(hse);
    cfg_vsize    = 13'd6;
    cfg_vend     = 13'd9;
    cfg_vs_start = 13'd7;
    cfg_vs_end   = 13'd8;
    cfg_hpol     = hp;
    cfg_vpol     = vp;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ((obs & IdleMask) !== idle_vec(0, 0) || frame_start !== 1'b0 || line_start !== 1'b0) begin
      n_fails++; $display("FAIL reset_outputs got %h want %h", obs, idle_vec(0, 0));
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (running !== 1'b0) begin
        n_fails++; $display("FAIL no_cfg_start got running=%b want 0", running);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_baseline;
    int de_px = 0;
    set_cfg(4, 14, 12, 0, 0);
    cfg_load = 1'b1; @(posedge clk); #1; cfg_load = 1'b0;
    en = 1'b1;
    kk = 0;
    for (int i = 0; i < 1500; i++) begin
      exp_q.push_back(exp_at(kk, 4, 14, 0, 0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL baseline k=%0d got %h want %h", kk, obs, exp_v);
      end
      if (kk < 750 && pix_ce && de) de_px++;
      kk++;
    end
    n_checks++;
    if (de_px !== 48) begin n_fails++; $display("FAIL de_count got %0d want 48", de_px); end
  endtask

  task automatic test_invalid;
    for (int i = 0; i < 1600; i++) begin
      if (kk == 1520) begin set_cfg(4, 14, 16, 0, 0); cfg_load = 1'b1; end
      else if (kk == 2300) begin set_cfg(4, 14, 12, 0, 0); cfg_load = 1'b1; end
      else cfg_load = 1'b0;
      exp_q.push_back(exp_at(kk, 4, 14, 0, 0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL invalid_timing k=%0d got %h want %h", kk, obs, exp_v);
      end
      if (kk == 1520 || kk == 2300) begin
        n_checks++;
        if (cfg_err !== (kk == 1520)) begin
          n_fails++; $display("FAIL cfg_err k=%0d got %b want %b", kk, cfg_err, kk == 1520);
        end
      end
      kk++;
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_stop;
    // Brief en drop, then a real stop at line 4.
    while (kk != 3750) begin
      if (kk >= 3100 && kk < 3103) en = 1'b0;
      else if (kk >= 3300) en = 1'b0;
      else en = 1'b1;
      exp_q.push_back(exp_at(kk, 4, 14, 0, 0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL stop_timing k=%0d got %h want %h", kk, obs, exp_v);
      end
      kk++;
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(idle_vec(0, 0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ((obs & IdleMask) !== exp_v) begin
        n_fails++; $display("FAIL stop_idle i=%0d got %h want %h", i, obs & IdleMask, exp_v);
      end
    end
  endtask

  task automatic test_polarity;
    set_cfg(4, 14, 12, 1, 1);
    cfg_load = 1'b1; @(posedge clk); #1; cfg_load = 1'b0;
    n_checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1 || running !== 1'b0) begin
      n_fails++; $display("FAIL idle_pol got hs=%b vs=%b run=%b want 1 1 0", hsync, vsync, running);
    end
    en = 1'b1;
    kk = 0;
    for (int i = 0; i < 750; i++) begin
      exp_q.push_back(exp_at(kk, 4, 14, 1, 1));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL polarity k=%0d got %h want %h", kk, obs, exp_v);
      end
      kk++;
    end
  endtask

  task automatic test_reload;
    int base = 0;
    int he = 14;
    for (int i = 0; i < 1700; i++) begin
      cfg_load = (kk == 975);
      if (kk == 975) set_cfg(4, 19, 12, 1, 1);
      if (he == 14 && kk > 975 && kk % 750 == 0) begin base = kk; he = 19; end
      exp_q.push_back(exp_at(kk - base, 4, he, 1, 1));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL reload k=%0d got %h want %h", kk, obs, exp_v);
      end
      if (kk == 976) begin
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL reload_err got %b want 0", cfg_err); end
      end
      kk++;
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_reset_mid;
    set_cfg(4, 14, 12, 0, 0);
    cfg_load = 1'b1; @(posedge clk); #1; cfg_load = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ((obs & IdleMask) !== idle_vec(0, 0) || frame_start !== 1'b0 || line_start !== 1'b0 ||
        cfg_err !== 1'b0) begin
      n_fails++; $display("FAIL reset_mid got %h want %h", obs, idle_vec(0, 0));
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (running !== 1'b0) begin
        n_fails++; $display("FAIL reset_cfg_lost got running=%b want 0", running);
      end
    end
  endtask

  task automatic test_pcnt0;
    en = 1'b0;
    set_cfg(0, 14, 12, 0, 0);
    cfg_load = 1'b1; @(posedge clk); #1; cfg_load = 1'b0;
    en = 1'b1;
    kk = 0;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(exp_at(kk, 0, 14, 0, 0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++; $display("FAIL pcnt0 k=%0d got %h want %h", kk, obs, exp_v);
      end
      kk++;
    end
  endtask

  initial begin
    test_reset;
    test_baseline;
    test_invalid;
    test_stop;
    test_polarity;
    test_reload;
    test_reset_mid;
    test_pcnt0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
